ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_basic.sv | 33 +++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, default widths
// and the round-robin pick used when requests are sampled.
package ram_arb_pkg;

   localparam int DATAWIDTH_DEF   = 32'd8;
   localparam int ADRESSWIDTH_DEF = 32'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // A lone requester always wins; on contention the pointer decides.
   function automatic logic arb_winner(input logic req0, input logic req1, input logic ptr);
      logic win;
      if (req0 && req1) begin
         win = ptr;
      end else if (req1) begin
         win = 1'b1;
      end else begin
         win = 1'b0;
      end
      return win;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request ports plus grant,
// read-return and busy signalling.
interface ram_arbiter_if #(
   parameter int datawidth   = ram_arb_pkg::DATAWIDTH_DEF,
   parameter int adresswidth = ram_arb_pkg::ADRESSWIDTH_DEF
);

   logic                   req0;
   logic                   req1;
   logic                   we0;
   logic                   we1;
   logic [adresswidth-1:0] addr0;
   logic [adresswidth-1:0] addr1;
   logic [datawidth-1:0]   wdata0;
   logic [datawidth-1:0]   wdata1;
   logic                   gnt0;
   logic                   gnt1;
   logic                   rvalid0;
   logic                   rvalid1;
   logic [datawidth-1:0]   rdata0;
   logic [datawidth-1:0]   rdata1;
   logic                   busy;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
   );

endinterface

// File: rtl/ram_basic.sv
// Single-port synchronous RAM: write on the clock edge, registered read data.
// Reset only clears the output register, never the array.
module RAM_basic #(
   parameter int datawidth   = 32'd8,
   parameter int adresswidth = 32'd10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [adresswidth-1:0] addr,
   input  logic [datawidth-1:0]   din,
   output logic [datawidth-1:0]   dout
);

   logic [datawidth-1:0] mem_r [0:(2**adresswidth)-1];

   // Storage array update.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= din;
      end
   end

   // Registered read port, one cycle behind the address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= '0;
      end else begin
         dout <= mem_r[addr];
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter letting two requesters share one RAM_basic instance.
// Writes take IDLE+CMD; reads take IDLE+CMD+RESP with rdata captured on leaving RESP.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int datawidth   = DATAWIDTH_DEF,
   parameter int adresswidth = ADRESSWIDTH_DEF
) (
   input logic          clk,
   input logic          reset,
   ram_arbiter_if.slave bus
);

   arb_state_t             state_r;
   logic                   ptr_r;
   logic                   owner_r;
   logic                   we_r;
   logic [adresswidth-1:0] addr_r;
   logic [datawidth-1:0]   wdata_r;
   logic                   gnt0_r;
   logic                   gnt1_r;
   logic                   rvalid0_r;
   logic                   rvalid1_r;
   logic [datawidth-1:0]   rdata0_r;
   logic [datawidth-1:0]   rdata1_r;
   logic                   busy_r;

   logic                   any_req_s;
   logic                   winner_s;
   logic                   ram_we_s;
   logic [datawidth-1:0]   ram_dout_s;

   // Request decode and RAM write strobe; the strobe depends only on reset-cleared state.
   always_comb begin
      any_req_s = bus.req0 | bus.req1;
      winner_s  = arb_winner(bus.req0, bus.req1, ptr_r);
      if ((state_r == CMD) && we_r) begin
         ram_we_s = 1'b1;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   // Arbitration FSM with registered grant, read-return and busy outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         ptr_r     <= 1'b0;
         owner_r   <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= '0;
         wdata_r   <= '0;
         gnt0_r    <= 1'b0;
         gnt1_r    <= 1'b0;
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         rdata0_r  <= '0;
         rdata1_r  <= '0;
         busy_r    <= 1'b0;
      end else begin
         gnt0_r    <= 1'b0;
         gnt1_r    <= 1'b0;
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  state_r <= CMD;
                  busy_r  <= 1'b1;
                  owner_r <= winner_s;
                  ptr_r   <= ~winner_s;
                  gnt0_r  <= ~winner_s;
                  gnt1_r  <= winner_s;
                  we_r    <= winner_s ? bus.we1    : bus.we0;
                  addr_r  <= winner_s ? bus.addr1  : bus.addr0;
                  wdata_r <= winner_s ? bus.wdata1 : bus.wdata0;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            CMD: begin
               if (we_r) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= RESP;
                  busy_r  <= 1'b1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               // Only the owner's read register moves; the other port keeps its last result.
               if (owner_r) begin
                  rdata1_r  <= ram_dout_s;
                  rvalid1_r <= 1'b1;
               end else begin
                  rdata0_r  <= ram_dout_s;
                  rvalid0_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   RAM_basic #(
      .datawidth   (datawidth),
      .adresswidth (adresswidth)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we_s),
      .addr  (addr_r),
      .din   (wdata_r),
      .dout  (ram_dout_s)
   );

   assign bus.gnt0    = gnt0_r;
   assign bus.gnt1    = gnt1_r;
   assign bus.rvalid0 = rvalid0_r;
   assign bus.rvalid1 = rvalid1_r;
   assign bus.rdata0  = rdata0_r;
   assign bus.rdata1  = rdata1_r;
   assign bus.busy    = busy_r;

endmodule
